jt1943_rom_arb: RTL
===================

# jt1943_rom_arb

Round-robin arbiter that shares the single SDRAM read port of the framework among four game ROM clients: main CPU, sound CPU, tile (char/scroll) fetch and object fetch. It sits between the 1943 game core's ROM clients and the framework's `sdram_req`/`sdram_ack`/`data_rdy` handshake. It sequences one 32-bit read at a time and latches the result into a per-client data register tagged with its address. It also drives `refresh_en` whenever the port is idle.

## Interface
- `AW`, 22: SDRAM word address width.
- `DW`, 32: SDRAM read data width.
- `clk  in  1`: system clock (48 MHz domain).
- `rst  in  1`: asynchronous, active-high reset.
- `downloading  in  1`: ROM download in progress. Holds the arbiter idle.
- `req  in  4`: per-client read request (level); bit 0 is main CPU, bit 3 is objects.
- `addr  in  4*AW`: per-client word address, client i at `[i*AW +: AW]`. Stable while `req[i]` is high.
- `dout  out  4*DW`: per-client latched data.
- `ok  out  4`: per-client data valid for the current `addr`.
- `sdram_req  out  1`: read request to the framework.
- `sdram_addr  out  AW`: read address.
- `sdram_ack  in  1`: framework accepted the request.
- `data_rdy  in  1`: `data_read` valid this cycle.
- `data_read  in  DW`: SDRAM read data.
- `refresh_en  out  1`: framework may refresh.

## Operation
- FSM states:
  - IDLE: if `downloading` is high, stay. Otherwise pick a pending client: `req[i]` high and not hit (`valid[i]` and `tag[i]==addr[i]`). Search starts at `last+1` mod 4. Register `sdram_addr<=addr[i]`, `cur<=i`, `sdram_req<=1`, go to REQ. If no client is pending, stay.
  - REQ: hold `sdram_req` and `sdram_addr` until `sdram_ack` is sampled high. Then drop `sdram_req` and go to WAIT. If `data_rdy` is also high in that cycle, treat it as WAIT's completion and go straight to IDLE. `data_rdy` seen in REQ without `sdram_ack` is ignored.
  - WAIT: on `data_rdy`: `dout[cur]<=data_read`, `tag[cur]<=sdram_addr`, `valid[cur]<=1`, `last<=cur`, go to IDLE.
- `ok[i]` is registered, computed every cycle as `req[i] & valid[i] & (tag[i]==addr[i])`.
- If a client changes `addr` mid-read, the fetched word is still stored under the old tag. `ok` stays low and the client is re-arbitrated.
- `refresh_en` = (state==IDLE) & no pending client. Registered.
- `downloading` high: FSM forced to IDLE the next cycle. This includes abandoning REQ/WAIT and dropping `sdram_req`. All `valid` are cleared and `ok` goes to 0. `refresh_en` follows the idle rule.
- Reset values: state IDLE, `sdram_req` 0, `sdram_addr` 0, `dout` 0, `ok` 0, `valid` 0, `last` 3 (so client 0 is searched first), `refresh_en` 0.

## Timing
- Miss latency: `req` at cycle 0, then `sdram_req` at cycle 1. With ack at cycle k and `data_rdy` at cycle m>k, `dout` is updated at m+1 and `ok` rises at m+2.
- Hit: a `req` rising on the tagged address gives `ok` at cycle 1 with no SDRAM access.
- `req[i]` low at cycle n gives `ok[i]` low at n+1.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0. No client waits more than 3 transactions.
- One outstanding read at most. `sdram_req` never re-asserts in the cycle it drops.

## Configuration
- `JT1943_ROM_ARB_CACHE_EN` defined: `valid[i]` persists after `req[i]` falls. A repeated request to the same address hits with no SDRAM cycle.
- Not defined: `valid[i]` is cleared in any cycle where `req[i]` is low. Every new request fetches from SDRAM.
- Handshake timing is otherwise identical in both builds.

## Structure
- Shared package `jt1943_rom_pkg`: client index constants (`ROM_MAIN=0`, `ROM_SND=1`, `ROM_TILE=2`, `ROM_OBJ=3`), FSM state enum (`ARB_IDLE`, `ARB_REQ`, `ARB_WAIT`), `AW`/`DW` defaults.
- One sub-module: `jt1943_rr_pick`, combinational. Takes a 4-bit pending mask and `last`, returns a grant index and an any-pending flag.

## Test plan
- Single miss: `req=0001`, `addr0=0x01234`, ack 3 cycles later, `data_rdy` 5 cycles later with `0xDEADBEEF` → `sdram_addr=0x01234`, `dout0=0xDEADBEEF`, `ok=0001` at `data_rdy`+2.
- Contention: `req=1111`, all addresses distinct, SDRAM model acks every request → grant order 0,1,2,3. `refresh_en` stays 0 until all `ok=1111`.
- Address change mid-read: client 2 switches `0x100`→`0x104` while in WAIT → `tag2=0x100`, `ok2` stays 0, second fetch issues `0x104`, then `ok2=1`.
- Cache: `req0` drops and rises again with the same `0x200` → with the macro, `ok0` at cycle 1 and no `sdram_req`; without it, a full SDRAM fetch.
- Download abort: `downloading=1` during REQ → `sdram_req=0` next cycle, `ok=0000`. After `downloading=0`, pending requests are refetched.
- Async reset asserted during WAIT → all outputs 0 immediately. After release, `refresh_en=1` once idle with `req=0000`.

Source files
------------

// File: rtl/jt1943_rom_pkg.sv
// rtl/jt1943_rom_pkg.sv - client indices, FSM states and width defaults for the 1943 ROM arbiter
package jt1943_rom_pkg;

    localparam int ROM_AW = 22;
    localparam int ROM_DW = 32;

    localparam logic [1:0] ROM_MAIN = 2'd0;
    localparam logic [1:0] ROM_SND  = 2'd1;
    localparam logic [1:0] ROM_TILE = 2'd2;
    localparam logic [1:0] ROM_OBJ  = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/jt1943_rom_arb_if.sv
// rtl/jt1943_rom_arb_if.sv - SDRAM read-port handshake between the ROM arbiter and the framework
interface jt1943_rom_arb_if #(
    parameter int AW = 22,
    parameter int DW = 32
);
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [DW-1:0] data_read;
    logic          refresh_en;

    modport master (
        output sdram_req, sdram_addr, refresh_en,
        input  sdram_ack, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr, refresh_en,
        output sdram_ack, data_rdy, data_read
    );
endinterface

// File: rtl/jt1943_rr_pick.sv
// rtl/jt1943_rr_pick.sv - combinational round-robin pick among four pending clients
module jt1943_rr_pick (
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any
);
    logic [1:0] idx;
    logic       found;

    // Search starts just after the last served client; last itself is tried at the end.
    always_comb begin
        grant = last;
        found = 1'b0;
        idx   = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && pending[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/jt1943_rom_arb.sv
// rtl/jt1943_rom_arb.sv - four-client round-robin SDRAM ROM read arbiter with tagged data registers
// Optional: JT1943_ROM_ARB_CACHE_EN keeps per-client data valid after its request falls.
module jt1943_rom_arb
    import jt1943_rom_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             downloading,
    input  logic [3:0]       req,
    input  logic [4*AW-1:0]  addr,
    output logic [4*DW-1:0]  dout,
    output logic [3:0]       ok,
    jt1943_rom_arb_if.master sdram
);

`ifdef JT1943_ROM_ARB_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    arb_state_t         state, state_nxt;
    logic [3:0][AW-1:0] addr_v;
    logic [3:0][AW-1:0] tag;
    logic [3:0][DW-1:0] dout_q;
    logic [3:0]         valid, valid_nxt, hit, pending;
    logic [1:0]         last, cur, grant;
    logic               any_pending, issue, complete;

    assign addr_v = addr;
    assign dout   = dout_q;

    always_comb begin
        hit = '0;
        for (int i = 0; i < 4; i++) hit[i] = valid[i] && (tag[i] == addr_v[i]);
    end

    assign pending = req & ~hit;

    jt1943_rr_pick u_pick (
        .pending (pending),
        .last    (last),
        .grant   (grant),
        .any     (any_pending)
    );

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        complete  = 1'b0;
        if (downloading) begin
            state_nxt = ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: if (any_pending) begin
                    issue     = 1'b1;
                    state_nxt = ARB_REQ;
                end
                // data_rdy alongside ack closes the read here; alone it is ignored
                ARB_REQ: if (sdram.sdram_ack) begin
                    complete  = sdram.data_rdy;
                    state_nxt = sdram.data_rdy ? ARB_IDLE : ARB_WAIT;
                end
                ARB_WAIT: if (sdram.data_rdy) begin
                    complete  = 1'b1;
                    state_nxt = ARB_IDLE;
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_nxt = valid;
        if (complete) valid_nxt[cur] = 1'b1;
        if (!CACHE_EN) valid_nxt = valid_nxt & req;
        if (downloading) valid_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram.sdram_req  <= 1'b0;
            sdram.sdram_addr <= '0;
            sdram.refresh_en <= 1'b0;
            cur              <= ROM_MAIN;
            last             <= ROM_OBJ;
            tag              <= '0;
            dout_q           <= '0;
            valid            <= '0;
            ok               <= '0;
        end else begin
            sdram.sdram_req <= (state_nxt == ARB_REQ);
            if (issue) begin
                sdram.sdram_addr <= addr_v[grant];
                cur              <= grant;
            end
            // The tag is the address sent, so a client that moved on mid-read still misses
            if (complete) begin
                dout_q[cur] <= sdram.data_read;
                tag[cur]    <= sdram.sdram_addr;
                last        <= cur;
            end
            valid            <= valid_nxt;
            ok               <= downloading ? 4'b0000 : (req & hit);
            sdram.refresh_en <= (state == ARB_IDLE) && !any_pending;
        end
    end

endmodule
